// File: rtl/pll_reset_gen.sv
// Holds downstream logic in reset until the PLL lock flag has been stable long enough.
// Define PLL_RESET_LOSS_CNT_EN to enable the saturating filtered lock-loss counter on loss_count.
module pll_reset_gen #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOSS_FILTER = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       sw_reset_req,
    output logic       reset_out,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StHold     = 2'd1,
        StRun      = 2'd2
    } state_e;

    localparam logic [15:0] HoldLast  = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]  LossLimit = 8'(LOSS_FILTER);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [15:0]            hold_cnt_q, hold_cnt_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic                   filtered_loss;
    logic                   reset_out_q, ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        loss_cnt_d    = 8'd0;
        filtered_loss = 1'b0;
        case (state_q)
            StHold: begin
                if (sw_reset_req || !locked_s) begin
                    state_d = StWaitLock;
                end else if (hold_cnt_q >= HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            StRun: begin
                // Loss counter only runs across consecutive low samples; any high sample clears it.
                if (!locked_s) begin
                    loss_cnt_d = (loss_cnt_q < LossLimit) ? loss_cnt_q + 8'd1 : loss_cnt_q;
                    filtered_loss = (loss_cnt_d >= LossLimit);
                end
                if (sw_reset_req || filtered_loss) begin
                    state_d = StWaitLock;
                end
            end
            default: begin
                // Also catches the unreachable encoding 3.
                hold_cnt_d = 16'd0;
                state_d    = locked_s ? StHold : StWaitLock;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StWaitLock;
            hold_cnt_q  <= 16'd0;
            loss_cnt_q  <= 8'd0;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            reset_out_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
        end
    end

    assign reset_out = reset_out_q;
    assign ready     = ready_q;
    assign state     = state_q;

`ifdef PLL_RESET_LOSS_CNT_EN
    logic [7:0] loss_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            loss_count_q <= 8'd0;
        end else if (filtered_loss && (loss_count_q != 8'hff)) begin
            loss_count_q <= loss_count_q + 8'd1;
        end
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_gen.sv
// Directed bench for pll_reset_gen with HOLD_CYCLES=16, SYNC_STAGES=2, LOSS_FILTER=4.
module tb_pll_reset_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       sw_reset_req;
    logic       reset_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_count;

    int total = 0;
    int bad   = 0;

`ifdef PLL_RESET_LOSS_CNT_EN
    localparam int LossInc = 1;
`else
    localparam int LossInc = 0;
`endif

    pll_reset_gen #(
        .HOLD_CYCLES(16),
        .SYNC_STAGES(2),
        .LOSS_FILTER(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .sw_reset_req(sw_reset_req),
        .reset_out   (reset_out),
        .ready       (ready),
        .state       (state),
        .loss_count  (loss_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic ro, input logic rdy, input logic [1:0] st);
        chk({tag, ".reset_out"}, 32'(reset_out), 32'(ro));
        chk({tag, ".ready"}, 32'(ready), 32'(rdy));
        chk({tag, ".state"}, 32'(state), 32'(st));
    endtask

    initial begin
        reset        = 1'b1;
        locked       = 1'b1;
        sw_reset_req = 1'b0;
        tick(2);
        chk_out("rst", 1'b1, 1'b0, 2'd0);
        chk("rst.loss_count", 32'(loss_count), 32'd0);

        // Release: locked_s rises after 2 edges, reset_out drops after edge 2+17.
        reset = 1'b0;
        tick(18);
        chk_out("rel.before", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("rel.after", 1'b0, 1'b1, 2'd2);

        // 3-cycle low pulse in RUN is filtered out.
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(6);
        chk_out("pulse3", 1'b0, 1'b1, 2'd2);
        chk("pulse3.loss_count", 32'(loss_count), 32'd0);

        // 4-cycle low is a loss: reset_out rises after the 6th edge.
        locked = 1'b0;
        tick(4);
        locked = 1'b1;
        tick(1);
        chk_out("loss4.before", 1'b0, 1'b1, 2'd2);
        tick(1);
        chk_out("loss4.after", 1'b1, 1'b0, 2'd0);
        chk("loss4.loss_count", 32'(loss_count), 32'(LossInc));
        tick(16);
        chk_out("loss4.hold", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("loss4.rerun", 1'b0, 1'b1, 2'd2);

        // Software reset request from RUN.
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk_out("sw.after", 1'b1, 1'b0, 2'd0);
        chk("sw.loss_count", 32'(loss_count), 32'(LossInc));
        tick(16);
        chk_out("sw.hold", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("sw.rerun", 1'b0, 1'b1, 2'd2);
        chk("sw.loss_count2", 32'(loss_count), 32'(LossInc));

        // Drop locked for one cycle while the hold counter sits at 10.
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(9);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        chk_out("hold10.in", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("hold10.drop", 1'b1, 1'b0, 2'd0);
        tick(16);
        chk_out("hold10.hold", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("hold10.rerun", 1'b0, 1'b1, 2'd2);

        // Reset in RUN, then in HOLD.
        reset = 1'b1;
        tick(1);
        chk_out("rstrun", 1'b1, 1'b0, 2'd0);
        chk("rstrun.loss_count", 32'(loss_count), 32'd0);
        reset = 1'b0;
        tick(10);
        chk_out("midhold", 1'b1, 1'b0, 2'd1);
        reset = 1'b1;
        tick(1);
        chk_out("rsthold", 1'b1, 1'b0, 2'd0);
        chk("rsthold.loss_count", 32'(loss_count), 32'd0);
        reset = 1'b0;
        tick(18);
        chk_out("rehold", 1'b1, 1'b0, 2'd1);
        tick(1);
        chk_out("rerelease", 1'b0, 1'b1, 2'd2);

        // 300 forced losses saturate loss_count.
        for (int n = 0; n < 300; n++) begin
            locked = 1'b0;
            tick(4);
            locked = 1'b1;
            tick(19);
            chk("loop.state", 32'(state), 32'd2);
            if (n == 0) chk("loop.first", 32'(loss_count), 32'(LossInc));
        end
        chk("sat.loss_count", 32'(loss_count), (LossInc != 0) ? 32'd255 : 32'd0);

        reset = 1'b1;
        tick(1);
        chk_out("final", 1'b1, 1'b0, 2'd0);
        chk("final.loss_count", 32'(loss_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_gen.md
PLL_RESET_GEN -- requirements
Module: pll_reset_gen

Interface
REQ-001 Parameters SHALL be HOLD_CYCLES, default 1024, consecutive synchronized-lock cycles required before reset release (legal 2..65535).
REQ-002 Parameters SHALL include SYNC_STAGES, default 2, synchronizer depth on locked (legal 2..4).
REQ-003 Parameters SHALL include LOSS_FILTER, default 4, consecutive synchronized-low cycles that count as a lock loss in RUN (legal 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be, clock and reset first:
  clock         in   1   PLL output clock (clock_out of the 180 MHz PLL); sole clock
  reset         in   1   synchronous active-high reset
  locked        in   1   PLL lock flag, asynchronous to clock
  sw_reset_req  in   1   single-cycle request to re-run the reset sequence
  reset_out     out  1   registered active-high synchronous reset for downstream logic
  ready         out  1   registered; 1 only in RUN
  state         out  2   current FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RUN
  loss_count    out  8   filtered lock-loss counter (see Configuration)

Function
REQ-006 locked SHALL pass through SYNC_STAGES flops before use; locked_s denotes the last stage.
REQ-007 The FSM SHALL have exactly three states: WAIT_LOCK, HOLD, RUN; state 3 is unreachable and SHALL decode as WAIT_LOCK.
REQ-008 WAIT_LOCK: reset_out=1, ready=0; locked_s=1 -> HOLD with hold counter cleared to 0.
REQ-009 HOLD: reset_out=1; each cycle with locked_s=1 increments the hold counter; locked_s=0 -> WAIT_LOCK immediately; counter == HOLD_CYCLES-1 with locked_s=1 -> RUN.
REQ-010 The first cycle locked_s=1 in WAIT_LOCK is cycle 0; reset_out SHALL read 0 first in cycle HOLD_CYCLES+1 with locked_s held high throughout.
REQ-011 RUN: reset_out=0, ready=1; a loss counter counts consecutive locked_s=0 cycles and clears whenever locked_s=1.
REQ-012 RUN: loss counter reaching LOSS_FILTER -> WAIT_LOCK; reset_out=1 in the next cycle.
REQ-013 Low pulses shorter than LOSS_FILTER cycles in RUN SHALL NOT affect reset_out.
REQ-014 sw_reset_req=1 in HOLD or RUN -> WAIT_LOCK next cycle; in WAIT_LOCK it is ignored.
REQ-015 sw_reset_req and a filtered loss in the same cycle -> WAIT_LOCK; counts as one loss event.
REQ-016 Hold counter width SHALL be 16 bits; it SHALL NOT wrap (it stops at HOLD_CYCLES-1).
REQ-017 Loss counter width SHALL be 8 bits; it saturates at LOSS_FILTER.
REQ-018 reset_out and ready SHALL be flop outputs with no combinational path from any input.

Reset
REQ-019 reset=1 at a clock edge SHALL set: state WAIT_LOCK, reset_out=1, ready=0, hold counter 0, loss counter 0, all sync flops 0, loss_count 0.
REQ-020 reset SHALL take priority over every other input, including mid-HOLD and in RUN.
REQ-021 After reset deasserts, the full SYNC_STAGES + HOLD_CYCLES sequence SHALL repeat even if locked stayed high.

Configuration
REQ-022 Macro PLL_RESET_LOSS_CNT_EN defined: loss_count increments by 1 on each RUN->WAIT_LOCK transition caused by a filtered loss, saturates at 255, and is cleared only by reset.
REQ-023 sw_reset_req-only exits SHALL NOT increment loss_count.
REQ-024 Macro PLL_RESET_LOSS_CNT_EN undefined: the loss_count port SHALL remain present, tied to 0, with no counter logic.

Verification
REQ-025 HOLD_CYCLES=16: reset, then locked=1 held -> reset_out=1 for 16+1 cycles after first locked_s=1, then 0; ready=1 and state=2 on the same cycle.
REQ-026 In HOLD at count 10, locked low 1 cycle -> state=0; release occurs 17 cycles after the next locked_s rise.
REQ-027 In RUN, LOSS_FILTER=4: 3-cycle low pulse -> no change; 4-cycle low -> reset_out=1 next cycle and loss_count 0->1 with the macro, 0 without.
REQ-028 In RUN, pulse sw_reset_req for 1 cycle -> reset_out=1 next cycle, state=0, loss_count unchanged; re-release after 17 cycles.
REQ-029 Assert reset mid-HOLD and mid-RUN -> all outputs at reset values next edge; 300 forced losses -> loss_count stops at 255.
